pulse_width_meter: RTL and testbench
====================================

// Module: pulse_width_meter
// PURPOSE
//  Downstream consumer of the programmable delay line output. Measures the high
//  time of each pulse on a single-bit strobe, in clk cycles, and reports it on a
//  valid/ready interface. Glitch filter drops short pulses; busy periods count drops.
//  Single clock domain; signal_in is already synchronous to clk.
// PARAMETERS
//  CNT_W      16  width of the pulse-width counter and the meas_width result
//  MIN_WIDTH   1  shortest reported pulse in cycles; 1..2^CNT_W-1; shorter is discarded
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      reset, synchronous, active-low
//  enable      in   1      1 = measuring allowed
//  signal_in   in   1      strobe to measure (delay line output)
//  meas_width  out  CNT_W  measured high time in cycles; held while meas_valid
//  meas_ovf    out  1      counter saturated during this pulse; qualified by meas_valid
//  meas_valid  out  1      result available
//  meas_ready  in   1      consumer accepts result
//  drop_cnt    out  8      rising edges ignored while in REPORT; saturates at 255
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE. cnt=0. meas_width=0. meas_ovf=0.
//   meas_valid=0. drop_cnt=0. busy=0. sig_q=1.
//   sig_q=1 means a pulse already high at reset release is never measured.
//  Edge detect: sig_q <= signal_in every cycle. rise = signal_in & ~sig_q.
//  A pulse's width N = number of consecutive clk edges that sample signal_in=1.
//  FSM, 3 states:
//   IDLE:    rise & enable -> MEASURE, cnt<=1, ovf_r<=0.
//            A rise with enable=0 is ignored; it is not counted as a drop.
//   MEASURE: enable=0 -> IDLE; pulse aborted; no report.
//            signal_in=1 -> cnt<=cnt+1.
//              At all-ones, cnt holds at all-ones and ovf_r<=1.
//            signal_in=0 with cnt>=MIN_WIDTH -> REPORT.
//              meas_width<=cnt, meas_ovf<=ovf_r, meas_valid<=1.
//            signal_in=0 with cnt<MIN_WIDTH -> IDLE; pulse silently discarded.
//   REPORT:  meas_valid, meas_width and meas_ovf are stable until handshake.
//            Handshake = meas_valid & meas_ready at an edge:
//              meas_valid<=0.
//              If rise & enable on the same edge -> MEASURE, cnt<=1; no drop counted.
//              Otherwise -> IDLE.
//            Rise without handshake -> drop_cnt<=drop_cnt+1, saturating at 255.
//            enable is ignored in REPORT.
//  Latency: for a pulse sampled high at edges t..t+N-1, meas_valid=1 after edge t+N.
//  Back-to-back pulses with a 1-cycle low gap: the second rise falls in REPORT.
//   It is measured only if the handshake completes on that same edge; else it is dropped.
//  A pulse still high on return to IDLE is not measured (no rise).
//  Mid-operation reset aborts any measurement and clears every output,
//   including a pending meas_valid.
//  meas_ready is a don't-care when meas_valid=0.
// STRUCTURE
//  Package pwm_pkg: state enum {IDLE, MEASURE, REPORT}; DROP_W=8 constant.
//  Sub-module edge_rise_det: sig_q register, reset value 1; outputs rise.
//  Top: FSM, saturating counters, output registers. All outputs are registered.
// TESTING  (CNT_W=8 unless noted)
//  1. MIN_WIDTH=1. 5-cycle pulse, meas_ready=1.
//     -> meas_valid for 1 cycle, 5 cycles after the first high sample;
//        meas_width=5, meas_ovf=0.
//  2. MIN_WIDTH=3. 2-cycle pulse then 3-cycle pulse.
//     -> first pulse gives no meas_valid; second gives meas_width=3.
//  3. 300-cycle pulse.
//     -> meas_width=255, meas_ovf=1.
//  4. meas_ready=0. 4 pulses of width 2, gaps 3.
//     -> meas_width=2 held; drop_cnt=3.
//     Then meas_ready=1 -> meas_valid falls next edge, busy=0.
//  5. signal_in=1 during and after reset.
//     -> no measurement until a 0->1 transition.
//     Also: rst_n=0 in REPORT -> meas_valid=0 and drop_cnt=0 at the next edge.
//  6. enable dropped mid-pulse (width 10, enable=0 at cycle 4).
//     -> no report, state IDLE.
//     Also: handshake and rise on the same edge -> next pulse measured, drop_cnt unchanged.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the pulse-width meter: FSM state encoding,
// drop-counter width and its saturating increment.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    localparam int DROP_W = 8;

    function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector on an already-synchronous strobe. The history register
// resets high so a strobe that is high when reset releases produces no rise.
module edge_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic signal_in,
    output logic rise
);

    logic r_sig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig_q <= 1'b1;
        end else begin
            r_sig_q <= signal_in;
        end
    end

    assign rise = signal_in & ~r_sig_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures the high time of each strobe pulse in clk cycles and reports it
// over valid/ready; rises arriving while a result is pending are counted as drops.
module pulse_width_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MIN_WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              signal_in,
    output logic [CNT_W-1:0]  meas_width,
    output logic              meas_ovf,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam logic [CNT_W-1:0] MIN_W_C = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_meas_width;
    logic              r_meas_ovf;
    logic              r_meas_valid;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_busy;

    logic w_rise;
    logic w_start;
    logic w_count;
    logic w_report;
    logic w_ack;
    logic w_drop;

    edge_rise_det u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal_in (signal_in),
        .rise      (w_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_count     = 1'b0;
        w_report    = 1'b0;
        w_ack       = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise && enable) begin
                    w_state_nxt = MEASURE;
                    w_start     = 1'b1;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (signal_in) begin
                    w_count = 1'b1;
                end else if (r_cnt >= MIN_W_C) begin
                    w_state_nxt = REPORT;
                    w_report    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REPORT: begin
                // A rise on the accepting edge starts the next measurement instead of dropping.
                if (r_meas_valid && meas_ready) begin
                    w_ack = 1'b1;
                    if (w_rise && enable) begin
                        w_state_nxt = MEASURE;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_rise) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_meas_width <= '0;
            r_meas_ovf   <= 1'b0;
            r_meas_valid <= 1'b0;
            r_drop_cnt   <= '0;
            r_busy       <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt <= ONE_C;
                r_ovf <= 1'b0;
            end else if (w_count) begin
                if (&r_cnt) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + ONE_C;
                end
            end
            if (w_report) begin
                r_meas_width <= r_cnt;
                r_meas_ovf   <= r_ovf;
                r_meas_valid <= 1'b1;
            end else if (w_ack) begin
                r_meas_valid <= 1'b0;
            end
            if (w_drop) begin
                r_drop_cnt <= drop_inc(r_drop_cnt);
            end
            r_busy <= (w_state_nxt != IDLE);
        end
    end

    assign meas_width = r_meas_width;
    assign meas_ovf   = r_meas_ovf;
    assign meas_valid = r_meas_valid;
    assign drop_cnt   = r_drop_cnt;
    assign busy       = r_busy;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: two instances (MIN_WIDTH 1 and 3, CNT_W 8) share
// stimulus; a transaction-level model is compared every cycle, plus directed literals.
module tb_pulse_width_meter;

    localparam int CNT_W = 8;
    localparam int MAXV  = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, signal_in, meas_ready;
    logic [CNT_W-1:0] w1, w3;
    logic ovf1, ovf3, v1, v3, b1, b3;
    logic [7:0] d1, d3;

    pulse_width_meter #(.CNT_W(CNT_W), .MIN_WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .signal_in(signal_in),
        .meas_width(w1), .meas_ovf(ovf1), .meas_valid(v1), .meas_ready(meas_ready),
        .drop_cnt(d1), .busy(b1)
    );

    pulse_width_meter #(.CNT_W(CNT_W), .MIN_WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .signal_in(signal_in),
        .meas_width(w3), .meas_ovf(ovf3), .meas_valid(v3), .meas_ready(meas_ready),
        .drop_cnt(d3), .busy(b3)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model view: phase 0 = waiting for a rise, 1 = timing a pulse, 2 = holding a result.
    typedef struct packed {
        int phase;
        int cnt;
        bit ovf_run;
        int width;
        bit ovf;
        bit valid;
        int drop;
    } model_t;

    model_t m1, m3;
    bit     m_prev;

    function automatic model_t model_next(input model_t s, input int minw, input bit rise,
                                          input bit en, input bit sig, input bit rdy);
        model_t n = s;
        if (s.phase == 0) begin
            if (rise && en) begin
                n.phase = 1; n.cnt = 1; n.ovf_run = 0;
            end
        end else if (s.phase == 1) begin
            if (!en) begin
                n.phase = 0;
            end else if (sig) begin
                if (s.cnt == MAXV) n.ovf_run = 1;
                else n.cnt = s.cnt + 1;
            end else if (s.cnt >= minw) begin
                n.phase = 2; n.width = s.cnt; n.ovf = s.ovf_run; n.valid = 1;
            end else begin
                n.phase = 0;
            end
        end else begin
            if (s.valid && rdy) begin
                n.valid = 0;
                if (rise && en) begin
                    n.phase = 1; n.cnt = 1; n.ovf_run = 0;
                end else begin
                    n.phase = 0;
                end
            end else if (rise) begin
                n.drop = (s.drop < 255) ? s.drop + 1 : 255;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m1     <= '0;
            m3     <= '0;
            m_prev <= 1'b1;
        end else begin
            m1     <= model_next(m1, 1, signal_in & ~m_prev, enable, signal_in, meas_ready);
            m3     <= model_next(m3, 3, signal_in & ~m_prev, enable, signal_in, meas_ready);
            m_prev <= signal_in;
        end
    end

    task automatic cmp_dut(input string tag, input model_t s, input logic v, input logic [7:0] w,
                           input logic o, input logic [7:0] d, input logic b);
        check({tag, ".valid"}, v, s.valid);
        check({tag, ".width"}, w, s.width);
        check({tag, ".ovf"},   o, s.ovf);
        check({tag, ".drop"},  d, s.drop);
        check({tag, ".busy"},  b, s.phase != 0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut("model1", m1, v1, w1, ovf1, d1, b1);
            cmp_dut("model3", m3, v3, w3, ovf3, d3, b3);
        end
    end

    task automatic step(input bit en, input bit sig, input bit rdy, input bit rn);
        enable = en; signal_in = sig; meas_ready = rdy; rst_n = rn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n, input bit en, input bit sig, input bit rdy, input bit rn);
        for (int i = 0; i < n; i++) step(en, sig, rdy, rn);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; signal_in = 1'b0; meas_ready = 1'b0;
        @(negedge clk);
        steps(3, 0, 0, 0, 0);
        cmp_en = 1'b1;
        check("reset.valid", v1, 0);
        check("reset.width", w1, 0);
        check("reset.drop",  d1, 0);
        check("reset.busy",  b1, 0);

        // Five-cycle pulse with ready high.
        steps(2, 1, 0, 1, 1);
        steps(5, 1, 1, 1, 1);
        check("t1.valid_early", v1, 0);
        step(1, 0, 1, 1);
        check("t1.valid", v1, 1);
        check("t1.width", w1, 5);
        check("t1.ovf",   ovf1, 0);
        check("t1.width_min3", w3, 5);
        step(1, 0, 1, 1);
        check("t1.valid_one_cycle", v1, 0);
        check("t1.busy_after", b1, 0);

        // Short pulse below MIN_WIDTH=3, then one at exactly 3.
        steps(2, 1, 1, 1, 1);
        step(1, 0, 1, 1);
        check("t2.short_valid_min3", v3, 0);
        check("t2.short_busy_min3",  b3, 0);
        check("t2.short_width_min1", w1, 2);
        steps(2, 1, 0, 1, 1);
        steps(3, 1, 1, 1, 1);
        step(1, 0, 1, 1);
        check("t2.valid_min3", v3, 1);
        check("t2.width_min3", w3, 3);
        steps(2, 1, 0, 1, 1);

        // Saturation boundary: 255 exact, then 300.
        steps(255, 1, 1, 1, 1);
        step(1, 0, 1, 1);
        check("t3.w255", w1, 255);
        check("t3.ovf255", ovf1, 0);
        steps(2, 1, 0, 1, 1);
        steps(300, 1, 1, 1, 1);
        step(1, 0, 1, 1);
        check("t3.w300", w1, 255);
        check("t3.ovf300", ovf1, 1);
        check("t3.ovf300_min3", ovf3, 1);
        steps(2, 1, 0, 1, 1);

        // Back-pressure: four width-2 pulses with ready low.
        for (int k = 0; k < 4; k++) begin
            steps(2, 1, 1, 0, 1);
            steps(3, 1, 0, 0, 1);
        end
        check("t4.valid", v1, 1);
        check("t4.width", w1, 2);
        check("t4.drop",  d1, 3);
        check("t4.valid_min3", v3, 0);
        check("t4.drop_min3",  d3, 0);
        step(1, 0, 1, 1);
        check("t4.valid_ack", v1, 0);
        check("t4.busy_ack",  b1, 0);

        // Enable removed mid-pulse.
        steps(3, 1, 1, 1, 1);
        check("t6.busy_mid", b1, 1);
        steps(7, 0, 1, 1, 1);
        step(1, 0, 1, 1);
        check("t6.abort_valid", v1, 0);
        check("t6.abort_busy",  b1, 0);
        check("t6.abort_busy_min3", b3, 0);

        // Handshake and rise on the same edge.
        steps(2, 1, 1, 0, 1);
        step(1, 0, 0, 1);
        check("t6.pending", v1, 1);
        step(1, 1, 1, 1);
        check("t6.ack_rise_valid", v1, 0);
        check("t6.ack_rise_busy",  b1, 1);
        check("t6.ack_rise_drop",  d1, 3);
        steps(2, 1, 1, 1, 1);
        step(1, 0, 1, 1);
        check("t6.second_width", w1, 3);
        check("t6.second_valid", v1, 1);
        check("t6.second_drop",  d1, 3);
        check("t6.second_min3",  w3, 3);
        steps(2, 1, 0, 1, 1);

        // Strobe high through reset release.
        steps(3, 1, 1, 1, 0);
        steps(5, 1, 1, 1, 1);
        check("t5.high_busy",  b1, 0);
        check("t5.high_valid", v1, 0);
        check("t5.high_drop",  d1, 0);
        step(1, 0, 1, 1);
        steps(2, 1, 1, 1, 1);
        step(1, 0, 1, 1);
        check("t5.after_rise_width", w1, 2);
        step(1, 0, 1, 1);

        // Reset while a result is pending.
        steps(2, 1, 1, 0, 1);
        step(1, 0, 0, 1);
        steps(2, 1, 1, 0, 1);
        step(1, 0, 0, 1);
        check("t5.pend_drop", d1, 1);
        step(1, 0, 0, 0);
        check("t5.rst_valid", v1, 0);
        check("t5.rst_drop",  d1, 0);
        check("t5.rst_busy",  b1, 0);
        step(1, 0, 0, 1);

        // Randomised run-length stimulus.
        begin
            int  cyc = 0;
            bit  sig = 1'b0;
            while (cyc < 6000) begin
                int run;
                run = ($urandom_range(0, 39) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 8);
                sig = ~sig;
                for (int i = 0; i < run; i++) begin
                    step(($urandom_range(0, 29) != 0), sig, ($urandom_range(0, 3) != 0),
                         ($urandom_range(0, 799) != 0));
                    cyc++;
                end
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
